hub75_scan_ctrl: RTL and testbench
==================================

Name: hub75_scan_ctrl

Overview:
- Scan sequencer for the 64x64 HUB75 panel (two 32-line halves, six colour bits per column).
- Drives `line`/`column` addresses into a combinational pattern source (ROM/LUT) and registers the returned r1..b2 bits onto the panel data pins.
- Generates the panel shift clock, latch, output-enable and row address.
- Sits between any pattern source and the panel pins.

Parameters:
- COLS, 64, columns shifted per line (power of 2, column width = log2(COLS)).
- LINES, 32, lines per half-panel (power of 2, line width = log2(LINES)).
- CLK_DIV, 2, sys cycles per hub_clk phase (>=2); one column slot = 2*CLK_DIV cycles.
- ON_CYCLES, 512, sys cycles OE is active per line (>= shift time recommended).
- BLANK_CYCLES, 4, sys cycles of blanking before and after latch.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run scan; sampled only at line boundaries
- line  out  5  line address to pattern source
- column  out  6  column address to pattern source
- r1,g1,b1,r2,g2,b2  in  1 each  pattern bits for (line, column), combinational
- hub_r1,hub_g1,hub_b1,hub_r2,hub_g2,hub_b2  out  1 each  registered panel data
- hub_clk  out  1  panel shift clock
- hub_lat  out  1  panel latch, active high
- hub_oe_n  out  1  panel output enable, active low
- hub_addr  out  5  panel row address (line currently displayed)
- frame_start  out  1  1-cycle pulse when shifting of line 0 begins

Behaviour:
- Reset (async, rst_n=0), all registers:
  - state=IDLE; line, column, hub_addr = 0.
  - hub_* data, hub_clk, hub_lat, frame_start = 0; hub_oe_n = 1.
  - primed = 0; all counters 0.
- States: IDLE, SHIFT, WAIT, BLANK_PRE, LATCH, BLANK_POST.
- IDLE: hub_oe_n=1. On enable=1 go to SHIFT with line=0, column=0, frame_start=1 for that cycle.
- SHIFT, per column slot c (cycles 0..2*CLK_DIV-1 of the slot):
  - column=c throughout; hub data registered at end of cycle 0.
  - hub_clk=0 for cycles 0..CLK_DIV-1, hub_clk=1 for cycles CLK_DIV..2*CLK_DIV-1.
  - After the slot for c=COLS-1, go to WAIT; column wraps to 0.
- OE during SHIFT/WAIT: hub_oe_n=0 iff primed=1, displaying hub_addr (previous line). on_cnt increments each cycle hub_oe_n=0.
- WAIT: hub_clk=0; stay until on_cnt >= ON_CYCLES, or primed=0 (exit immediately); then go to BLANK_PRE.
- BLANK_PRE: hub_oe_n=1 for BLANK_CYCLES cycles.
- LATCH: 1 cycle. hub_lat=1, hub_addr<=line, primed<=1, on_cnt<=0.
- BLANK_POST: hub_oe_n=1 for BLANK_CYCLES cycles; then:
  - line <= line+1 (wraps LINES-1 -> 0).
  - If enable=1, go to SHIFT; frame_start=1 in the first SHIFT cycle when the new line is 0.
  - If enable=0, go to IDLE (primed kept; panel stays blank).
- Latency: pattern bit for column c appears on hub_* in cycle 1 of slot c and is stable through the rising hub_clk edge.
- Line period = COLS*2*CLK_DIV + max(0, ON_CYCLES − shift time) + 2*BLANK_CYCLES + 1.
- Boundary conditions:
  - enable falling mid-line has no effect until BLANK_POST ends.
  - Reset mid-operation blanks immediately (hub_oe_n=1 asynchronously).
  - on_cnt saturates at ON_CYCLES.
  - hub_lat is never high while hub_oe_n=0.

Optional Feature:
- SCAN_BRIGHTNESS_EN defined: adds input `brightness [3:0]`, sampled at LATCH. OE is active only while on_cnt < (ON_CYCLES*(brightness+1))>>4; the remainder of the dwell is blanked. brightness=15 gives full on-time; line period is unchanged.
- Not defined: no port; OE is active for the full dwell.

Decomposition:
- Shared package (hub75_pkg): state encoding, default COLS/LINES, derived widths (clog2), BLANK/LATCH defaults.
- One sub-module is natural: hub75_clk_gen (slot phase counter producing slot_start, hub_clk, slot_end from CLK_DIV).
- The FSM and counters stay in hub75_scan_ctrl.

Test Plan:
- Reset: hold rst_n=0 with enable=1 -> hub_oe_n=1, hub_lat=0, hub_clk=0, line=column=0; release, 1 cycle later frame_start=1.
- Shift timing (CLK_DIV=2): pattern r1=column[0] -> 64 hub_clk rising edges per line; hub_r1 toggles 0,1,0,1… sampled on each rising edge; first rise 2 cycles after SHIFT entry.
- First line unprimed: after enable, hub_oe_n stays 1 through line 0 shift; the first hub_lat pulse has hub_addr=0 and hub_oe_n=1; hub_oe_n first goes to 0 in line 1's SHIFT with hub_addr=0.
- Dwell/wrap (ON_CYCLES=512): each line period = 256+256+9 = 521 cycles; after line 31 latch, hub_addr goes 31->0 and frame_start pulses at line 0 shift start; full frame = 32*521 cycles.
- Enable drop: deassert enable mid-SHIFT of line 5 -> line 5 completes through LATCH (hub_addr=5), then IDLE with hub_oe_n=1 and no further hub_clk edges.
- SCAN_BRIGHTNESS_EN, brightness=7 -> OE low for exactly 256 cycles per line, line period still 521; brightness=15 -> 512 cycles.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 64x64 scan sequencer.
package hub75_pkg;

    localparam int unsigned HUB_COLS         = 64;
    localparam int unsigned HUB_LINES        = 32;
    localparam int unsigned HUB_CLK_DIV      = 2;
    localparam int unsigned HUB_ON_CYCLES    = 512;
    localparam int unsigned HUB_BLANK_CYCLES = 4;
    localparam int unsigned HUB_COL_W        = $clog2(HUB_COLS);
    localparam int unsigned HUB_LINE_W       = $clog2(HUB_LINES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_BLANK_PRE,
        ST_LATCH,
        ST_BLANK_POST
    } scan_state_t;

    // Six colour bits for one column: upper half (1) and lower half (2).
    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } hub_rgb_t;

endpackage

// File: rtl/hub75_clk_gen.sv
// Column-slot phase counter: marks slot start/end and drives the panel shift clock.
module hub75_clk_gen
    import hub75_pkg::*;
#(
    parameter int unsigned CLK_DIV = HUB_CLK_DIV,
    localparam int unsigned PH_W   = $clog2(2 * CLK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic slot_start_c,
    output logic slot_end_c,
    output logic hub_clk
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_n;

    assign slot_start_c = run && (phase == '0);
    assign slot_end_c   = run && (phase == PH_LAST);

    always_comb begin
        phase_n = '0;
        if (run && !slot_end_c) begin
            phase_n = phase + 1'b1;
        end
    end

    // hub_clk is high in the second half of each slot, aligned to the phase it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            hub_clk <= 1'b0;
        end else begin
            phase   <= phase_n;
            hub_clk <= (phase_n >= PH_W'(CLK_DIV));
        end
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: shift, dwell, blank, latch per line across the panel.
// Optional SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that trims OE on-time.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS         = HUB_COLS,
    parameter int unsigned LINES        = HUB_LINES,
    parameter int unsigned CLK_DIV      = HUB_CLK_DIV,
    parameter int unsigned ON_CYCLES    = HUB_ON_CYCLES,
    parameter int unsigned BLANK_CYCLES = HUB_BLANK_CYCLES,
    localparam int unsigned COL_W       = $clog2(COLS),
    localparam int unsigned LINE_W      = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [3:0]        brightness,
`endif
    output logic [LINE_W-1:0] line,
    output logic [COL_W-1:0]  column,
    input  logic              r1,
    input  logic              g1,
    input  logic              b1,
    input  logic              r2,
    input  logic              g2,
    input  logic              b2,
    output logic              hub_r1,
    output logic              hub_g1,
    output logic              hub_b1,
    output logic              hub_r2,
    output logic              hub_g2,
    output logic              hub_b2,
    output logic              hub_clk,
    output logic              hub_lat,
    output logic              hub_oe_n,
    output logic [LINE_W-1:0] hub_addr,
    output logic              frame_start
);

    localparam int unsigned ON_W  = $clog2(ON_CYCLES + 1);
    localparam int unsigned BLK_W = $clog2(BLANK_CYCLES + 1);

    scan_state_t       state, state_n;
    logic [LINE_W-1:0] line_n, hub_addr_n;
    logic [COL_W-1:0]  column_n;
    logic              primed, primed_n;
    logic [ON_W-1:0]   on_cnt, on_cnt_n, on_limit;
    logic [BLK_W-1:0]  blank_cnt, blank_cnt_n;
    logic              hub_lat_n, hub_oe_n_n, frame_start_n;
    logic              dwell_done;
    hub_rgb_t          rgb_c, hub_rgb, hub_rgb_n;
    logic              slot_start_c, slot_end_c, shift_run_c;

    assign shift_run_c = (state == ST_SHIFT);
    assign rgb_c       = {r1, g1, b1, r2, g2, b2};
    assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = hub_rgb;

    hub75_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (shift_run_c),
        .slot_start_c (slot_start_c),
        .slot_end_c   (slot_end_c),
        .hub_clk      (hub_clk)
    );

`ifdef SCAN_BRIGHTNESS_EN
    logic [ON_W+4:0] bright_prod_c;
    assign bright_prod_c = (ON_W+5)'(ON_CYCLES) * (ON_W+5)'({1'b0, brightness} + 5'd1);

    // On-time limit for the next displayed line, captured while latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_limit <= ON_W'(ON_CYCLES);
        end else if (state == ST_LATCH) begin
            on_limit <= ON_W'(bright_prod_c >> 4);
        end
    end
`else
    assign on_limit = ON_W'(ON_CYCLES);
`endif

    always_comb begin
        state_n       = state;
        line_n        = line;
        column_n      = column;
        hub_addr_n    = hub_addr;
        primed_n      = primed;
        on_cnt_n      = on_cnt;
        blank_cnt_n   = blank_cnt;
        hub_rgb_n     = hub_rgb;
        frame_start_n = 1'b0;

        // Dwell counter runs through shift and wait once a line is latched, saturating.
        if ((state == ST_SHIFT || state == ST_WAIT) && primed && (on_cnt < ON_W'(ON_CYCLES))) begin
            on_cnt_n = on_cnt + 1'b1;
        end
        dwell_done = !primed || (on_cnt_n >= ON_W'(ON_CYCLES));

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n       = ST_SHIFT;
                    line_n        = '0;
                    column_n      = '0;
                    frame_start_n = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (slot_start_c) begin
                    hub_rgb_n = rgb_c;
                end
                if (slot_end_c) begin
                    column_n = column + 1'b1;
                    if (column == COL_W'(COLS - 1)) begin
                        state_n     = dwell_done ? ST_BLANK_PRE : ST_WAIT;
                        blank_cnt_n = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (dwell_done) begin
                    state_n     = ST_BLANK_PRE;
                    blank_cnt_n = '0;
                end
            end
            ST_BLANK_PRE: begin
                blank_cnt_n = blank_cnt + 1'b1;
                if (blank_cnt == BLK_W'(BLANK_CYCLES - 1)) begin
                    state_n    = ST_LATCH;
                    hub_addr_n = line;
                    primed_n   = 1'b1;
                    on_cnt_n   = '0;
                end
            end
            ST_LATCH: begin
                state_n     = ST_BLANK_POST;
                blank_cnt_n = '0;
            end
            ST_BLANK_POST: begin
                blank_cnt_n = blank_cnt + 1'b1;
                if (blank_cnt == BLK_W'(BLANK_CYCLES - 1)) begin
                    line_n = line + 1'b1;
                    if (enable) begin
                        state_n       = ST_SHIFT;
                        column_n      = '0;
                        frame_start_n = (line_n == '0);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        hub_lat_n  = (state_n == ST_LATCH);
        hub_oe_n_n = !((state_n == ST_SHIFT || state_n == ST_WAIT) && primed_n
                       && (on_cnt_n < on_limit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            line        <= '0;
            column      <= '0;
            hub_addr    <= '0;
            primed      <= 1'b0;
            on_cnt      <= '0;
            blank_cnt   <= '0;
            hub_rgb     <= '0;
            hub_lat     <= 1'b0;
            hub_oe_n    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            line        <= line_n;
            column      <= column_n;
            hub_addr    <= hub_addr_n;
            primed      <= primed_n;
            on_cnt      <= on_cnt_n;
            blank_cnt   <= blank_cnt_n;
            hub_rgb     <= hub_rgb_n;
            hub_lat     <= hub_lat_n;
            hub_oe_n    <= hub_oe_n_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: timing vectors, shifted data, dwell, latch and enable drop.
module tb_hub75_scan_ctrl;

    typedef struct {
        int cyc;
        int ln;
        int col;
        int hclk;
        int lat;
        int oe_n;
        int addr;
        int fs;
    } vec_t;

    localparam int NV  = 20;
    localparam int NV2 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [4:0] line;
    logic [5:0] column;
    logic       r1, g1, b1, r2, g2, b2;
    logic       hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic       hub_clk, hub_lat, hub_oe_n;
    logic [4:0] hub_addr;
    logic       frame_start;
`ifdef SCAN_BRIGHTNESS_EN
    logic [3:0] brightness;
`endif

    int   errors = 0;
    int   checks = 0;
    int   n = 0;
    int   rises = 0;
    int   rises_line = 0;
    int   oe_line = 0;
    int   lat_cnt = 0;
    int   exp_on = 512;
    logic prev_clk = 1'b0;
    vec_t vecs [NV];
    vec_t vecs2 [NV2];

    always #5 clk = ~clk;

    hub75_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef SCAN_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .line        (line),
        .column      (column),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .r2          (r2),
        .g2          (g2),
        .b2          (b2),
        .hub_r1      (hub_r1),
        .hub_g1      (hub_g1),
        .hub_b1      (hub_b1),
        .hub_r2      (hub_r2),
        .hub_g2      (hub_g2),
        .hub_b2      (hub_b2),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe_n    (hub_oe_n),
        .hub_addr    (hub_addr),
        .frame_start (frame_start)
    );

    // Pattern ROM stand-in: {r1,g1,b1,r2,g2,b2} as a function of line/column.
    function automatic logic [5:0] pat(input logic [4:0] l, input logic [5:0] c);
        pat = {c[0], c[1], l[0], c[5], l[4] ^ c[2], ~c[0]};
    endfunction

    always_comb {r1, g1, b1, r2, g2, b2} = pat(line, column);

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v);
        chk("line",        v.cyc, int'(line),        v.ln);
        chk("column",      v.cyc, int'(column),      v.col);
        chk("hub_clk",     v.cyc, int'(hub_clk),     v.hclk);
        chk("hub_lat",     v.cyc, int'(hub_lat),     v.lat);
        chk("hub_oe_n",    v.cyc, int'(hub_oe_n),    v.oe_n);
        chk("hub_addr",    v.cyc, int'(hub_addr),    v.addr);
        chk("frame_start", v.cyc, int'(frame_start), v.fs);
    endtask

    // Per-cycle observer: data at every shift-clock rise, per-line edge and OE counts at latch.
    task automatic monitor();
        logic [5:0] got;
        int le, ce;
        if (hub_clk && !prev_clk) begin
            ce  = rises % 64;
            le  = (rises / 64) % 32;
            got = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};
            chk("rise_data", n, int'(got), int'(pat(5'(le), 6'(ce))));
            rises++;
            rises_line++;
        end
        if (!hub_oe_n) oe_line++;
        if (hub_lat) begin
            chk("lat_while_oe", n, int'(hub_oe_n), 1);
            chk("rises_per_line", n, rises_line, 64);
            chk("oe_per_line", n, oe_line, (lat_cnt == 0) ? 0 : exp_on);
            lat_cnt++;
            rises_line = 0;
            oe_line    = 0;
        end
        prev_clk = hub_clk;
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_monitor();
        n          = 0;
        rises      = 0;
        rises_line = 0;
        oe_line    = 0;
        lat_cnt    = 0;
        prev_clk   = 1'b0;
    endtask

    initial begin
        int vi;
        //          cyc    ln col clk lat oe addr fs
        vecs[0]  = '{1,     0, 0,  0,  0, 1,  0, 1};
        vecs[1]  = '{2,     0, 0,  0,  0, 1,  0, 0};
        vecs[2]  = '{3,     0, 0,  1,  0, 1,  0, 0};
        vecs[3]  = '{5,     0, 1,  0,  0, 1,  0, 0};
        vecs[4]  = '{7,     0, 1,  1,  0, 1,  0, 0};
        vecs[5]  = '{256,   0, 63, 1,  0, 1,  0, 0};
        vecs[6]  = '{257,   0, 0,  0,  0, 1,  0, 0};
        vecs[7]  = '{261,   0, 0,  0,  1, 1,  0, 0};
        vecs[8]  = '{262,   0, 0,  0,  0, 1,  0, 0};
        vecs[9]  = '{266,   1, 0,  0,  0, 0,  0, 0};
        vecs[10] = '{522,   1, 0,  0,  0, 0,  0, 0};
        vecs[11] = '{777,   1, 0,  0,  0, 0,  0, 0};
        vecs[12] = '{778,   1, 0,  0,  0, 1,  0, 0};
        vecs[13] = '{782,   1, 0,  0,  1, 1,  1, 0};
        vecs[14] = '{787,   2, 0,  0,  0, 0,  1, 0};
        vecs[15] = '{15896, 31, 0, 0,  0, 0, 30, 0};
        vecs[16] = '{16412, 31, 0, 0,  1, 1, 31, 0};
        vecs[17] = '{16417, 0, 0,  0,  0, 0, 31, 1};
        vecs[18] = '{16418, 0, 0,  0,  0, 0, 31, 0};
        vecs[19] = '{16933, 0, 0,  0,  1, 1,  0, 0};
        vecs2[0] = '{2866,  5, 0,  0,  1, 1,  5, 0};
        vecs2[1] = '{2871,  6, 0,  0,  0, 1,  5, 0};

        rst_n  = 1'b0;
        enable = 1'b1;
`ifdef SCAN_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe_n",   0, int'(hub_oe_n),    1);
        chk("rst_lat",    0, int'(hub_lat),     0);
        chk("rst_clk",    0, int'(hub_clk),     0);
        chk("rst_line",   0, int'(line),        0);
        chk("rst_column", 0, int'(column),      0);
        chk("rst_fs",     0, int'(frame_start), 0);
        rst_n = 1'b1;

        // Full frame plus wrap into the next frame with enable held.
        vi = 0;
        for (int k = 0; k < 17000; k++) begin
            tick();
            if (vi < NV && vecs[vi].cyc == n) begin
                check_vec(vecs[vi]);
                vi++;
            end
        end
        chk("vectors_reached", n, vi, NV);

        // Reset while the panel is lit must blank without waiting for a clock edge.
        chk("pre_reset_oe_n", n, int'(hub_oe_n), 0);
        rst_n = 1'b0;
        #1;
        chk("async_oe_n", n, int'(hub_oe_n), 1);
        chk("async_line", n, int'(line),     0);
        chk("async_addr", n, int'(hub_addr), 0);

`ifdef SCAN_BRIGHTNESS_EN
        brightness = 4'd7;
        exp_on     = 256;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_monitor();
        rst_n = 1'b1;

        // Drop enable partway through line 5's shift.
        vi = 0;
        for (int k = 0; k < 3100; k++) begin
            tick();
            if (n == 2400) enable = 1'b0;
            if (vi < NV2 && vecs2[vi].cyc == n) begin
                check_vec(vecs2[vi]);
                vi++;
            end
        end
        chk("vectors2_reached", n, vi, NV2);
        chk("drop_lat_count", n, lat_cnt, 6);
        chk("idle_no_clk",    n, rises_line, 0);
        chk("idle_no_oe",     n, oe_line, 0);
        chk("idle_oe_n",      n, int'(hub_oe_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
